// File: rtl/ram_dma.sv
// Block-move / block-fill engine for the 16-bit RAM.
// It copies len words from src to dst, or it fills len words at dst with one value.
module ram_dma #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] count,
    output logic          mem_wen,
    output logic [DW-1:0] mem_din,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t        state_q;
    logic          mode_q;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [AW-1:0] rem_q;
    logic [AW-1:0] count_q;
    logic [DW-1:0] data_q;

    // The RAM sees state and pointer decodes only. The single combinational path is
    // abort gating the write enable, so an aborted word never reaches the RAM.
    assign busy     = (state_q == S_RD) || (state_q == S_WR);
    assign done     = (state_q == S_FIN);
    assign count    = count_q;
    assign mem_wen  = (state_q == S_WR) && !abort;
    assign mem_din  = data_q;
    assign mem_addr = (state_q == S_RD) ? src_q :
                      (state_q == S_WR) ? dst_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        src_q   <= src;
                        dst_q   <= dst;
                        rem_q   <= len;
                        count_q <= '0;
                        if (mode) data_q <= src[DW-1:0];
                        if (len == '0)  state_q <= S_FIN;
                        else if (mode)  state_q <= S_WR;
                        else            state_q <= S_RD;
                    end
                end
                S_RD: begin
                    if (abort) begin
                        state_q <= S_FIN;
                    end else begin
                        data_q  <= mem_dout;
                        src_q   <= src_q + AW'(1);
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    if (abort) begin
                        state_q <= S_FIN;
                    end else begin
                        dst_q   <= dst_q + AW'(1);
                        count_q <= count_q + AW'(1);
                        rem_q   <= rem_q - AW'(1);
                        if (rem_q == AW'(1)) state_q <= S_FIN;
                        else if (mode_q)     state_q <= S_WR;
                        else                 state_q <= S_RD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma. A word-level model of each operation builds a per-cycle expectation queue.
// The bench checks that queue every cycle and also checks hand-computed RAM contents.
module tb_ram_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, mem_wen;
    logic [15:0] count, mem_din, mem_addr, mem_dout;

    logic [15:0] ram     [0:65535];
    logic [15:0] exp_ram [0:65535];

    typedef struct {
        bit          busy;
        bit          done;
        bit          wen;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] cnt;
    } cyc_t;

    cyc_t        exp_q[$];
    logic [15:0] exp_count = '0;
    bit          mon_en = 1'b0;
    int          n_err = 0;
    int          n_chk = 0;

    ram_dma #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src(src), .dst(dst), .len(len), .abort(abort),
        .busy(busy), .done(done), .count(count),
        .mem_wen(mem_wen), .mem_din(mem_din), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = ram[mem_addr];
    always @(posedge clk) if (mem_wen) ram[mem_addr] <= mem_din;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic cyc_t mk(input bit b, input bit dn, input bit w,
                                input logic [15:0] a, input logic [15:0] di, input logic [15:0] c);
        cyc_t e;
        e.busy = b; e.done = dn; e.wen = w; e.addr = a; e.din = di; e.cnt = c;
        return e;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        ram[a] = v;
        exp_ram[a] = v;
    endtask

    always @(negedge clk) begin : compare
        cyc_t e;
        if (mon_en && rst_n) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy", {31'd0, busy}, {31'd0, e.busy});
                chk("done", {31'd0, done}, {31'd0, e.done});
                chk("mem_wen", {31'd0, mem_wen}, {31'd0, e.wen});
                chk("count", {16'd0, count}, {16'd0, e.cnt});
                if (e.busy) chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                if (e.wen)  chk("mem_din", {16'd0, mem_din}, {16'd0, e.din});
            end else begin
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("idle_done", {31'd0, done}, 32'd0);
                chk("idle_wen", {31'd0, mem_wen}, 32'd0);
                chk("idle_count", {16'd0, count}, {16'd0, exp_count});
            end
        end
    end

    // Word-level model: a copy is a forward read/write per word and a fill is one write per word.
    // abort_k is the index of the write cycle that gets cancelled (-1 means no abort).
    task automatic run_op(input bit m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input int abort_k, input bit noisy);
        cyc_t        q[$];
        int          ac = -1;
        int          c = 0;
        logic [15:0] cnt = '0;
        logic [15:0] a, w;
        for (int i = 0; i < int'(n); i++) begin
            a = s + 16'(i);
            if (!m) q.push_back(mk(1'b1, 1'b0, 1'b0, a, '0, cnt));
            if (i == abort_k) begin
                ac = q.size();
                q.push_back(mk(1'b1, 1'b0, 1'b0, d + 16'(i), '0, cnt));
                break;
            end
            w = m ? s : exp_ram[a];
            q.push_back(mk(1'b1, 1'b0, 1'b1, d + 16'(i), w, cnt));
            a = d + 16'(i);
            exp_ram[a] = w;
            cnt++;
        end
        q.push_back(mk(1'b0, 1'b1, 1'b0, '0, '0, cnt));

        @(posedge clk); #1;
        mode = m; src = s; dst = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q = q;
        exp_count = cnt;
        if (noisy) begin
            mode = ~m; src = ~s; dst = ~d; len = n + 16'd5;
        end
        while (exp_q.size() > 0) begin
            abort = (c == ac);
            start = noisy && (c >= 1);
            @(posedge clk); #1;
            c++;
            if (c > 1000) begin
                n_chk++; n_err++;
                $display("FAIL op_timeout: still %0d cycles pending, required 0", exp_q.size());
                exp_q.delete();
            end
        end
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            a = d + 16'(i);
            chk("ram_region", {16'd0, ram[a]}, {16'd0, exp_ram[a]});
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 16'(i) ^ 16'h5A5A;
            exp_ram[i] = 16'(i) ^ 16'h5A5A;
        end
        #1 rst_n = 1'b0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_din", {16'd0, mem_din}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1'b1;

        poke(16'h0010, 16'h00A1); poke(16'h0011, 16'h00B2);
        poke(16'h0012, 16'h00C3); poke(16'h0013, 16'h00D4);
        run_op(1'b0, 16'h0010, 16'h0040, 16'd4, -1, 1'b1);
        chk("copy_w0", {16'd0, ram[16'h0040]}, 32'h00A1);
        chk("copy_w1", {16'd0, ram[16'h0041]}, 32'h00B2);
        chk("copy_w2", {16'd0, ram[16'h0042]}, 32'h00C3);
        chk("copy_w3", {16'd0, ram[16'h0043]}, 32'h00D4);
        chk("copy_count", {16'd0, count}, 32'd4);

        poke(16'h0103, 16'h5555);
        run_op(1'b1, 16'hBEEF, 16'h0100, 16'd3, -1, 1'b0);
        chk("fill_w0", {16'd0, ram[16'h0100]}, 32'hBEEF);
        chk("fill_w2", {16'd0, ram[16'h0102]}, 32'hBEEF);
        chk("fill_untouched", {16'd0, ram[16'h0103]}, 32'h5555);
        chk("fill_count", {16'd0, count}, 32'd3);

        run_op(1'b0, 16'h0010, 16'h0500, 16'd0, -1, 1'b0);
        chk("len0_count", {16'd0, count}, 32'd0);
        chk("len0_untouched", {16'd0, ram[16'h0500]}, 32'h5F5A);

        poke(16'hFFFE, 16'h1111); poke(16'hFFFF, 16'h2222); poke(16'h0000, 16'h3333);
        run_op(1'b0, 16'hFFFE, 16'h0020, 16'd3, -1, 1'b0);
        chk("wrap_w0", {16'd0, ram[16'h0020]}, 32'h1111);
        chk("wrap_w1", {16'd0, ram[16'h0021]}, 32'h2222);
        chk("wrap_w2", {16'd0, ram[16'h0022]}, 32'h3333);

        for (int i = 0; i < 8; i++) poke(16'h0200 + 16'(i), 16'h9000 + 16'(i));
        poke(16'h0302, 16'h7777);
        run_op(1'b0, 16'h0200, 16'h0300, 16'd8, 2, 1'b0);
        chk("abort_count", {16'd0, count}, 32'd2);
        chk("abort_w0", {16'd0, ram[16'h0300]}, 32'h9000);
        chk("abort_w1", {16'd0, ram[16'h0301]}, 32'h9001);
        chk("abort_w2_kept", {16'd0, ram[16'h0302]}, 32'h7777);

        poke(16'h0600, 16'hAAAA);
        run_op(1'b0, 16'h0600, 16'h0601, 16'd3, -1, 1'b0);
        chk("overlap_w3", {16'd0, ram[16'h0603]}, 32'hAAAA);

        mon_en = 1'b0;
        @(posedge clk); #1;
        mode = 1'b0; src = 16'h0010; dst = 16'h0700; len = 16'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wen", {31'd0, mem_wen}, 32'd0);
        chk("arst_count", {16'd0, count}, 32'd0);
        chk("arst_addr", {16'd0, mem_addr}, 32'd0);
        chk("arst_din", {16'd0, mem_din}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ram[16'h0700] = 16'h00A1;
        exp_count = '0;
        chk("arst_word0", {16'd0, ram[16'h0700]}, 32'h00A1);
        chk("arst_word1_kept", {16'd0, ram[16'h0701]}, 32'h5D5B);
        mon_en = 1'b1;
        run_op(1'b1, 16'h1234, 16'h0700, 16'd2, -1, 1'b0);
        chk("post_rst_w1", {16'd0, ram[16'h0701]}, 32'h1234);
        chk("post_rst_count", {16'd0, count}, 32'd2);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
